// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0), shown when no instruction is valid.
  localparam logic [31:0] NOP = 32'h00000013;

  // Depth of the response and in-flight PC queues.
  localparam int QUEUE_DEPTH = 2;

  // Occupancy counter width: must hold 0..QUEUE_DEPTH.
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_resp_fifo.sv
// Two-entry FIFO with push, pop, synchronous clear and occupancy count.
// The head entry is always presented on head_data (valid when count != 0).
module fetch_resp_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 52
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_reg [QUEUE_DEPTH];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic do_push;
  logic do_pop;
  logic full;

  // Push is allowed into a full queue only when the head leaves the same cycle.
  assign full    = (count_reg == CNT_W'(QUEUE_DEPTH));
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && (!full || do_pop);

  // Entry storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (do_push && !clear) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/fetch_issue_unit.sv
// Instruction-fetch front end: owns the PC, issues word reads with up to two
// reads outstanding, queues in-order responses, and squashes responses that
// belong to the path abandoned by a redirect.
module fetch_issue_unit
  import fetch_pkg::*;
#(
  parameter int                      DATA_WIDTH   = 32,
  parameter int                      ADDRESS_BITS = 20,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stall,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_BITS-1:0] redirect_PC,
  input  logic                    JAL_detected,
  input  logic [ADDRESS_BITS-1:0] JAL_target,
  output logic                    imem_req,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  input  logic                    imem_ready,
  input  logic                    imem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   imem_resp_data,
  output logic [DATA_WIDTH-1:0]   instruction_fetch,
  output logic [ADDRESS_BITS-1:0] inst_PC_fetch,
  output logic                    valid_fetch
);

  localparam int ENTRY_W = ADDRESS_BITS + DATA_WIDTH;
  localparam logic [ADDRESS_BITS-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDRESS_BITS-1:2], 2'b00};
  localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~ADDRESS_BITS'(3);

  fetch_state_t            state_reg;
  logic [ADDRESS_BITS-1:0] pc_reg;
  logic [CNT_W-1:0]        drop_reg;

  // In-flight count is the occupancy of the PC-of-request queue.
  logic [CNT_W-1:0]        pc_count;
  logic [ADDRESS_BITS-1:0] req_pc_head;
  logic [CNT_W-1:0]        rsp_count;
  logic [ENTRY_W-1:0]      rsp_head;

  logic                    running;
  logic                    redirect_any;
  logic [ADDRESS_BITS-1:0] redirect_target;
  logic [ADDRESS_BITS-1:0] target_aligned;
  logic                    resp_fire;
  logic                    resp_push;
  logic                    pop_fetch;
  logic [CNT_W:0]          credit_used;
  logic                    accept;

  assign running = (state_reg == RUN);

  // Execute-stage redirect outranks the decode-stage JAL.
  assign redirect_any    = running && (redirect_valid || JAL_detected);
  assign redirect_target = redirect_valid ? redirect_PC : JAL_target;
  assign target_aligned  = redirect_target & ALIGN_MASK;

  // A response only counts when a read is actually outstanding; anything
  // arriving with nothing in flight (e.g. left over from before reset) is ignored.
  assign resp_fire = running && imem_resp_valid && (pc_count != '0);
  assign resp_push = resp_fire && !redirect_any && (drop_reg == '0);

  assign valid_fetch = (rsp_count != '0) && !redirect_any;
  assign pop_fetch   = valid_fetch && !stall;

  // The slot freed by this cycle's pop is reusable immediately, which is what
  // sustains one instruction per cycle with single-cycle memory while still
  // keeping outstanding reads plus queued responses at or below two.
  assign credit_used = {1'b0, pc_count} + {1'b0, rsp_count} - {{CNT_W{1'b0}}, pop_fetch};
  assign imem_req    = running && !redirect_valid && !JAL_detected
                       && (credit_used < (CNT_W + 1)'(QUEUE_DEPTH));
  assign accept      = imem_req && imem_ready;
  assign imem_addr   = pc_reg;

  // Control FSM with PC and squash counter; all state changes are registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC_ALIGNED;
      drop_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            pc_reg    <= RESET_PC_ALIGNED;
            drop_reg  <= '0;
          end
        end
        RUN: begin
          if (redirect_any) begin
            pc_reg   <= target_aligned;
            // Every read still outstanding after this cycle belongs to the
            // abandoned path; a response landing now is discarded on the spot.
            drop_reg <= pc_count - CNT_W'(resp_fire);
          end else begin
            if (accept) begin
              pc_reg <= pc_reg + ADDRESS_BITS'(4);
            end
            if (resp_fire && (drop_reg != '0)) begin
              drop_reg <= drop_reg - CNT_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // PC of each outstanding read, popped as its response returns.
  fetch_resp_fifo #(
    .WIDTH(ADDRESS_BITS)
  ) u_req_pc_q (
    .clock    (clock),
    .reset    (reset),
    .push     (accept),
    .push_data(pc_reg),
    .pop      (resp_fire),
    .clear    (1'b0),
    .head_data(req_pc_head),
    .count    (pc_count)
  );

  // Returned {PC, instruction} pairs waiting for the downstream stage.
  fetch_resp_fifo #(
    .WIDTH(ENTRY_W)
  ) u_rsp_q (
    .clock    (clock),
    .reset    (reset),
    .push     (resp_push),
    .push_data({req_pc_head, imem_resp_data}),
    .pop      (pop_fetch),
    .clear    (redirect_any),
    .head_data(rsp_head),
    .count    (rsp_count)
  );

  assign instruction_fetch = valid_fetch ? rsp_head[DATA_WIDTH-1:0] : DATA_WIDTH'(NOP);
  assign inst_PC_fetch     = valid_fetch ? rsp_head[ENTRY_W-1:DATA_WIDTH] : '0;

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed bench for fetch_issue_unit with a fixed-latency in-order memory.
module tb_fetch_issue_unit;
  import fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [19:0] redirect_PC = '0;
  logic        JAL_detected = 1'b0;
  logic [19:0] JAL_target = '0;
  logic        imem_req;
  logic [19:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instruction_fetch;
  logic [19:0] inst_PC_fetch;
  logic        valid_fetch;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int          dly_q[$];
  logic [19:0] adr_q[$];

  fetch_issue_unit dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_PC      (redirect_PC),
    .JAL_detected     (JAL_detected),
    .JAL_target       (JAL_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .instruction_fetch(instruction_fetch),
    .inst_PC_fetch    (inst_PC_fetch),
    .valid_fetch      (valid_fetch)
  );

  always #5 clock = ~clock;

  // Memory: record accepts on the rising edge, present responses from the falling edge.
  always @(clock) begin
    if (clock) begin
      if (imem_req === 1'b1 && imem_ready === 1'b1) begin
        adr_q.push_back(imem_addr);
        dly_q.push_back(mem_lat - 1);
      end
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      if (dly_q.size() > 0 && dly_q[0] == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = {12'hC0D, adr_q[0]};
        void'(dly_q.pop_front());
        void'(adr_q.pop_front());
      end
      for (int i = 0; i < dly_q.size(); i++) begin
        if (dly_q[i] > 0) dly_q[i] = dly_q[i] - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset, drain the memory, then pulse start; returns in cycle 1 (first request).
  task automatic restart(input int lat);
    reset = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    JAL_detected = 1'b0;
    imem_ready = 1'b1;
    repeat (6) tick();
    mem_lat = lat;
    reset = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== 20'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000", imem_addr); end
    checks++; if (valid_fetch !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_fetch); end
    checks++; if (instruction_fetch !== NOP) begin errors++; $display("FAIL reset_ins: got %h want %h", instruction_fetch, NOP); end
    checks++; if (inst_PC_fetch !== 20'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000", inst_PC_fetch); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    logic        ev;
    logic [19:0] ep;
    logic [31:0] ei;
    restart(1);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) tick();
      ev = (k >= 3);
      ep = ev ? 20'(4 * (k - 3)) : 20'h0;
      ei = ev ? {12'hC0D, ep} : NOP;
      checks++;
      if (valid_fetch !== ev || inst_PC_fetch !== ep || instruction_fetch !== ei) begin
        errors++;
        $display("FAIL seq_out c%0d: got v=%b pc=%h ins=%h want v=%b pc=%h ins=%h", k, valid_fetch, inst_PC_fetch, instruction_fetch, ev, ep, ei);
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 20'(4 * (k - 1))) begin
        errors++;
        $display("FAIL seq_req c%0d: got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 20'(4 * (k - 1)));
      end
    end
    $display("test_sequential done");
  endtask

  task automatic test_stall();
    logic [19:0] ep;
    logic        er;
    logic [19:0] ea;
    restart(1);
    tick();
    tick();
    for (int k = 3; k <= 10; k++) begin
      if (k > 3) tick();
      stall = (k <= 6);
      #1;
      ep = (k <= 6) ? 20'h0 : 20'(4 * (k - 7));
      er = (k > 6);
      ea = 20'(4 * (k - 5));
      checks++;
      if (valid_fetch !== 1'b1 || inst_PC_fetch !== ep || instruction_fetch !== {12'hC0D, ep}) begin
        errors++;
        $display("FAIL stall_out c%0d: got v=%b pc=%h ins=%h want v=1 pc=%h", k, valid_fetch, inst_PC_fetch, instruction_fetch, ep);
      end
      checks++;
      if (imem_req !== er || (er && imem_addr !== ea)) begin
        errors++;
        $display("FAIL stall_req c%0d: got req=%b addr=%h want req=%b addr=%h", k, imem_req, imem_addr, er, ea);
      end
    end
    stall = 1'b0;
    $display("test_stall done");
  endtask

  task automatic test_jal_squash();
    restart(2);
    tick();
    tick();
    JAL_detected = 1'b1;
    JAL_target = 20'h00100;
    #1;
    checks++; if (imem_req !== 1'b0 || valid_fetch !== 1'b0) begin errors++; $display("FAIL jal_cycle: got req=%b v=%b want 0 0", imem_req, valid_fetch); end
    tick();
    JAL_detected = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 20'h00100) begin errors++; $display("FAIL jal_req: got req=%b addr=%h want 1 00100", imem_req, imem_addr); end
    for (int k = 4; k <= 6; k++) begin
      if (k > 4) tick();
      checks++; if (valid_fetch !== 1'b0) begin errors++; $display("FAIL jal_gap c%0d: got v=%b pc=%h want v=0", k, valid_fetch, inst_PC_fetch); end
    end
    tick();
    checks++; if (valid_fetch !== 1'b1 || inst_PC_fetch !== 20'h00100 || instruction_fetch !== 32'hC0D00100) begin
      errors++; $display("FAIL jal_first: got v=%b pc=%h ins=%h want 1 00100 c0d00100", valid_fetch, inst_PC_fetch, instruction_fetch); end
    tick();
    checks++; if (valid_fetch !== 1'b1 || inst_PC_fetch !== 20'h00104) begin errors++; $display("FAIL jal_second: got v=%b pc=%h want 1 00104", valid_fetch, inst_PC_fetch); end
    $display("test_jal_squash done");
  endtask

  task automatic test_redirect_priority();
    restart(1);
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_PC = 20'h00200;
    JAL_detected = 1'b1;
    JAL_target = 20'h00300;
    #1;
    checks++; if (valid_fetch !== 1'b0 || instruction_fetch !== NOP || inst_PC_fetch !== 20'h0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL prio_cycle: got v=%b ins=%h pc=%h req=%b want 0 %h 00000 0", valid_fetch, instruction_fetch, inst_PC_fetch, imem_req, NOP); end
    tick();
    redirect_valid = 1'b0;
    JAL_detected = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 20'h00200 || valid_fetch !== 1'b0) begin
      errors++; $display("FAIL prio_req: got req=%b addr=%h v=%b want 1 00200 0", imem_req, imem_addr, valid_fetch); end
    tick();
    checks++; if (valid_fetch !== 1'b0) begin errors++; $display("FAIL prio_gap: got v=%b want 0", valid_fetch); end
    tick();
    checks++; if (valid_fetch !== 1'b1 || inst_PC_fetch !== 20'h00200) begin errors++; $display("FAIL prio_first: got v=%b pc=%h want 1 00200", valid_fetch, inst_PC_fetch); end
    tick();
    checks++; if (valid_fetch !== 1'b1 || inst_PC_fetch !== 20'h00204) begin errors++; $display("FAIL prio_second: got v=%b pc=%h want 1 00204", valid_fetch, inst_PC_fetch); end
    $display("test_redirect_priority done");
  endtask

  task automatic test_ready_and_align();
    restart(1);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) tick();
      imem_ready = (k == 4);
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 20'h0) begin errors++; $display("FAIL ready_hold c%0d: got req=%b addr=%h want 1 00000", k, imem_req, imem_addr); end
    end
    tick();
    checks++; if (imem_addr !== 20'h00004 || valid_fetch !== 1'b0) begin errors++; $display("FAIL ready_adv: got addr=%h v=%b want 00004 0", imem_addr, valid_fetch); end
    redirect_valid = 1'b1;
    redirect_PC = 20'h00206;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL align_noreq: got req=%b want 0", imem_req); end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 20'h00204) begin errors++; $display("FAIL align_req: got req=%b addr=%h want 1 00204", imem_req, imem_addr); end
    tick();
    checks++; if (valid_fetch !== 1'b0) begin errors++; $display("FAIL align_gap: got v=%b pc=%h want v=0", valid_fetch, inst_PC_fetch); end
    tick();
    checks++; if (valid_fetch !== 1'b1 || inst_PC_fetch !== 20'h00204) begin errors++; $display("FAIL align_first: got v=%b pc=%h want 1 00204", valid_fetch, inst_PC_fetch); end
    $display("test_ready_and_align done");
  endtask

  task automatic test_reset_midrun();
    restart(4);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 20'h0 || valid_fetch !== 1'b0 || instruction_fetch !== NOP || inst_PC_fetch !== 20'h0) begin
      errors++; $display("FAIL midrst_out: got req=%b addr=%h v=%b ins=%h pc=%h want 0 00000 0 %h 00000", imem_req, imem_addr, valid_fetch, instruction_fetch, inst_PC_fetch, NOP); end
    tick();
    tick();
    tick();
    reset = 1'b1;
    for (int k = 6; k <= 7; k++) begin
      if (k > 6) tick();
      #1;
      checks++; if (imem_req !== 1'b0 || valid_fetch !== 1'b0) begin errors++; $display("FAIL midrst_idle c%0d: got req=%b v=%b want 0 0", k, imem_req, valid_fetch); end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 20'h0 || valid_fetch !== 1'b0) begin
      errors++; $display("FAIL midrst_restart: got req=%b addr=%h v=%b want 1 00000 0", imem_req, imem_addr, valid_fetch); end
    tick();
    checks++; if (valid_fetch !== 1'b0) begin errors++; $display("FAIL midrst_stale: got v=%b pc=%h want v=0", valid_fetch, inst_PC_fetch); end
    $display("test_reset_midrun done");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_jal_squash();
    test_redirect_priority();
    test_ready_and_align();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
